ddr_local_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the DDR high-performance controller's local interface, in the `phy_clk` domain. It grants whole transactions (a read command, or a 1–2 beat write burst) to one of two requesters, drives the `local_*` request and burst signals, and returns read data to its issuing port through an in-order read-tag FIFO.

---
 rtl/ddr_local_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ddr_local_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_local_arbiter.sv
// Two-port transaction arbiter and sequencer for the DDR controller local interface.
// Build option: DDR_ARB_FIXED_PRIO_EN gives port 0 fixed priority instead of round-robin.
//
// state   | meaning
// IDLE    | wait for init_done and an eligible request, then register the grant
// RD_CMD  | read command on the bus until local_ready accepts it
// WR_BEAT | write beats on the bus until the last beat is accepted
module ddr_local_arbiter #(
  parameter int RD_FIFO_DEPTH = 4,
  parameter int ADDR_W        = 23
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [1:0]        p0_size,
  input  logic [31:0]       p0_wdata,
  input  logic [3:0]        p0_be,
  output logic              p0_wnext,
  output logic              p0_ack,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p1_size,
  input  logic [31:0]       p1_wdata,
  input  logic [3:0]        p1_be,
  output logic              p1_wnext,
  output logic              p1_ack,
  output logic              p1_rvalid,
  output logic [31:0]       rdata,
  input  logic              local_init_done,
  input  logic              local_ready,
  input  logic              local_rdata_valid,
  input  logic [31:0]       local_rdata,
  output logic [ADDR_W-1:0] local_address,
  output logic [1:0]        local_size,
  output logic              local_read_req,
  output logic              local_write_req,
  output logic              local_burstbegin,
  output logic [31:0]       local_wdata,
  output logic [3:0]        local_be,
  output logic              rd_unexpected
);

  localparam int PTR_W = (RD_FIFO_DEPTH > 2) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_CMD  = 2'd1;
  localparam logic [1:0] S_WR_BEAT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              beat_q, beat_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              head_beat_q, head_beat_d;
  logic              unexp_q, unexp_d;
  logic [1:0]        tag_q [RD_FIFO_DEPTH];

  logic       fifo_full, fifo_empty;
  logic       elig0, elig1, grant, grant_port, grant_we;
  logic [1:0] grant_size;
  logic       last_beat, done, wr_accept;
  logic       push, pop, rd_hit;
  logic [1:0] head_tag, tag_push;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  assign elig0 = p0_req & (p0_we | ~fifo_full);
  assign elig1 = p1_req & (p1_we | ~fifo_full);
  assign grant = local_init_done & (elig0 | elig1);

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign grant_port = elig1 & ~elig0;
`else
  // fav_q names the port that wins a tie; the last-granted port loses the next one
  logic fav_q, fav_d;

  assign grant_port = (elig0 & elig1) ? fav_q : elig1;
  assign fav_d      = done ? ~owner_q : fav_q;

  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) fav_q <= 1'b0;
    else               fav_q <= fav_d;
  end
`endif

  assign grant_we   = grant_port ? p1_we : p0_we;
  assign grant_size = grant_port ? p1_size : p0_size;
  assign last_beat  = (beat_q == (size_q == 2'd2));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    size_d  = size_q;
    beat_d  = beat_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d = grant_port;
          addr_d  = grant_port ? p1_addr : p0_addr;
          size_d  = ((grant_size == 2'd2) || (grant_size == 2'd3)) ? 2'd2 : 2'd1;
          beat_d  = 1'b0;
          state_d = grant_we ? S_WR_BEAT : S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        if (local_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_BEAT: begin
        if (local_ready) begin
          beat_d = 1'b1;
          if (last_beat) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign local_read_req   = (state_q == S_RD_CMD);
  assign local_write_req  = (state_q == S_WR_BEAT);
  assign local_burstbegin = local_write_req & ~beat_q;
  assign local_address    = addr_q;
  assign local_size       = size_q;
  assign local_wdata      = local_write_req ? (owner_q ? p1_wdata : p0_wdata) : 32'h0;
  assign local_be         = local_write_req ? (owner_q ? p1_be : p0_be) : 4'h0;

  assign wr_accept = local_write_req & local_ready;
  assign p0_wnext  = wr_accept & ~owner_q;
  assign p1_wnext  = wr_accept & owner_q;
  assign p0_ack    = done & ~owner_q;
  assign p1_ack    = done & owner_q;

  // tag = {port, two_beat}; head_beat_q marks the first beat of a 2-beat head as consumed
  assign push        = local_read_req & local_ready;
  assign tag_push    = {owner_q, (size_q == 2'd2)};
  assign head_tag    = tag_q[rd_ptr_q];
  assign rd_hit      = local_rdata_valid & ~fifo_empty;
  assign pop         = rd_hit & (~head_tag[0] | head_beat_q);
  assign head_beat_d = rd_hit ? ~pop : head_beat_q;
  assign wr_ptr_d    = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
  assign cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
  assign unexp_d     = unexp_q | (local_rdata_valid & fifo_empty);

  assign p0_rvalid     = rd_hit & ~head_tag[1];
  assign p1_rvalid     = rd_hit & head_tag[1];
  assign rdata         = local_rdata;
  assign rd_unexpected = unexp_q;

  always_ff @(posedge phy_clk) begin
    if (push) tag_q[wr_ptr_q] <= tag_push;
  end

  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'd0;
      beat_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_beat_q <= 1'b0;
      unexp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_beat_q <= head_beat_d;
      unexp_q     <= unexp_d;
    end
  end

endmodule

// File: tb/tb_ddr_local_arbiter.sv
// Self-checking bench for ddr_local_arbiter: vector table, corner sequences, random traffic.
module tb_ddr_local_arbiter;
  localparam int ADDR_W = 23;
  localparam int DEPTH  = 4;

  logic              phy_clk = 1'b0;
  logic              reset_phy_clk = 1'b1;
  logic [1:0]        req, we;
  logic [ADDR_W-1:0] addr [2];
  logic [1:0]        size [2];
  logic [31:0]       wdata [2];
  logic [3:0]        be [2];
  logic [1:0]        wnext, ack, rvalid;
  logic [31:0]       rdata;
  logic              init_done, lready, rvalid_in;
  logic [31:0]       lrdata;
  logic [ADDR_W-1:0] laddr;
  logic [1:0]        lsize;
  logic              rd_req, wr_req, bb, unexp;
  logic [31:0]       lwdata;
  logic [3:0]        lbe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 phy_clk = ~phy_clk;

  ddr_local_arbiter #(.RD_FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .phy_clk(phy_clk), .reset_phy_clk(reset_phy_clk),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_size(size[0]),
    .p0_wdata(wdata[0]), .p0_be(be[0]), .p0_wnext(wnext[0]), .p0_ack(ack[0]), .p0_rvalid(rvalid[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_size(size[1]),
    .p1_wdata(wdata[1]), .p1_be(be[1]), .p1_wnext(wnext[1]), .p1_ack(ack[1]), .p1_rvalid(rvalid[1]),
    .rdata(rdata), .local_init_done(init_done), .local_ready(lready),
    .local_rdata_valid(rvalid_in), .local_rdata(lrdata), .local_address(laddr),
    .local_size(lsize), .local_read_req(rd_req), .local_write_req(wr_req),
    .local_burstbegin(bb), .local_wdata(lwdata), .local_be(lbe), .rd_unexpected(unexp)
  );

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [31:0]       w0;
    logic [31:0]       w1;
    logic [3:0]        be;
    int                lat;
    logic [1:0]        exp_size;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge phy_clk);
    #1;
  endtask

  function automatic int norm(input logic [1:0] s);
    return (s >= 2'd2) ? 2 : 1;
  endfunction

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; lready = 1'b0; rvalid_in = 1'b0; lrdata = 32'h0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; size[p] = 2'd0; wdata[p] = 32'h0; be[p] = 4'h0;
    end
  endtask

  task automatic do_reset();
    reset_phy_clk = 1'b1;
    idle_inputs();
    step();
    step();
    @(negedge phy_clk);
    chk("reset_ctl", {wnext, ack, rvalid, rd_req, wr_req, bb, unexp, lsize}, 64'h0);
    chk("reset_addr", laddr, 64'h0);
    chk("reset_wdata", {lwdata, lbe, rdata}, 64'h0);
    step();
    reset_phy_clk = 1'b0;
  endtask

  task automatic wait_ack(output logic [1:0] a, input int bound);
    a = 2'b00;
    for (int t = 0; t < bound; t++) begin
      @(negedge phy_clk);
      if (ack != 2'b00) begin
        a = ack;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic issue_rd(input int p, input logic [ADDR_W-1:0] a, input logic [1:0] s);
    logic [1:0] got;
    req[p] = 1'b1; we[p] = 1'b0; addr[p] = a; size[p] = s; lready = 1'b1;
    wait_ack(got, 10);
    chk($sformatf("issue_rd_p%0d", p), got, 2'b01 << p);
    req[p] = 1'b0;
    lready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int p, beats, acks, c;
    logic [1:0] one, exp_wn, exp_ack;
    p = v.port ? 1 : 0;
    one = 2'b01 << p;
    req[p] = 1'b1; we[p] = v.we; addr[p] = v.addr; size[p] = v.size;
    wdata[p] = v.w0; be[p] = v.be; lready = 1'b0;
    @(negedge phy_clk);
    chk($sformatf("v%0d_grant_cycle", idx), {rd_req, wr_req}, 2'b00);
    step();
    beats = 0; acks = 0; c = 0;
    while (acks == 0 && c < 20) begin
      lready = (c >= v.lat);
      wdata[p] = (beats == 0) ? v.w0 : v.w1;
      @(negedge phy_clk);
      if (v.we) begin
        chk($sformatf("v%0d_wr_req", idx), {rd_req, wr_req}, 2'b01);
        chk($sformatf("v%0d_burstbegin", idx), bb, (beats == 0));
        chk($sformatf("v%0d_wdata", idx), {lwdata, lbe}, {((beats == 0) ? v.w0 : v.w1), v.be});
      end else begin
        chk($sformatf("v%0d_rd_req", idx), {rd_req, wr_req}, 2'b10);
      end
      chk($sformatf("v%0d_addr_size", idx), {laddr, lsize}, {v.addr, v.exp_size});
      exp_wn  = (lready && v.we) ? one : 2'b00;
      exp_ack = (lready && (!v.we || beats == int'(v.exp_size) - 1)) ? one : 2'b00;
      chk($sformatf("v%0d_handshake", idx), {wnext, ack}, {exp_wn, exp_ack});
      if (wnext[p]) beats++;
      if (ack[p]) acks++;
      step();
      c++;
    end
    req[p] = 1'b0;
    lready = 1'b0;
    chk($sformatf("v%0d_acks", idx), acks, 1);
    if (v.we) chk($sformatf("v%0d_beats", idx), beats, v.exp_size);
    else begin
      for (int b = 0; b < int'(v.exp_size); b++) begin
        rvalid_in = 1'b1;
        lrdata = $urandom;
        @(negedge phy_clk);
        chk($sformatf("v%0d_rd_ret%0d", idx, b), {rvalid, rdata}, {one, lrdata});
        step();
      end
      rvalid_in = 1'b0;
    end
    chk($sformatf("v%0d_no_unexp", idx), unexp, 1'b0);
  endtask

  // random-traffic model state
  int                act [2];
  logic              t_we [2];
  logic [1:0]        t_size [2];
  logic [ADDR_W-1:0] t_addr [2];
  logic [31:0]       t_data [2][2];
  logic [3:0]        t_be [2][2];
  int                t_beat [2];
  int                ret_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] got, exp_rv;
    int n_busy, rd_seen, p0_acks, p1_acks;

    vt[0] = '{1'b0, 1'b1, 23'h000100, 2'd2, 32'hA0A0_0001, 32'hA0A0_0002, 4'hF, 3, 2'd2};
    vt[1] = '{1'b1, 1'b1, 23'h7FFFFF, 2'd0, 32'h1111_2222, 32'h0,         4'h3, 0, 2'd1};
    vt[2] = '{1'b0, 1'b1, 23'h000200, 2'd3, 32'hDEAD_0000, 32'hBEEF_0001, 4'hA, 1, 2'd2};
    vt[3] = '{1'b1, 1'b1, 23'h001234, 2'd1, 32'h5555_AAAA, 32'h0,         4'h8, 2, 2'd1};
    vt[4] = '{1'b0, 1'b0, 23'h000010, 2'd2, 32'h0,         32'h0,         4'h0, 1, 2'd2};
    vt[5] = '{1'b1, 1'b0, 23'h0ABCDE, 2'd3, 32'h0,         32'h0,         4'h0, 0, 2'd2};
    vt[6] = '{1'b0, 1'b0, 23'h000000, 2'd0, 32'h0,         32'h0,         4'h0, 2, 2'd1};
    vt[7] = '{1'b1, 1'b0, 23'h055555, 2'd1, 32'h0,         32'h0,         4'h0, 0, 2'd1};

    init_done = 1'b0;
    do_reset();

    // init_done gating, then 1-cycle request latency
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 23'h000123; size[0] = 2'd1;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge phy_clk);
      n_busy += int'(rd_req | wr_req);
      step();
    end
    chk("init_gate", n_busy, 0);
    init_done = 1'b1;
    @(negedge phy_clk);
    chk("init_idle_cycle", {rd_req, wr_req}, 2'b00);
    step();
    @(negedge phy_clk);
    chk("init_rd_req", {rd_req, wr_req, laddr, lsize}, {2'b10, 23'h000123, 2'd1});
    step();
    @(negedge phy_clk);
    chk("init_stable", {ack, rd_req, wr_req, laddr, lsize}, {2'b00, 2'b10, 23'h000123, 2'd1});
    step();
    lready = 1'b1;
    @(negedge phy_clk);
    chk("init_ack", ack, 2'b01);
    step();
    req[0] = 1'b0; lready = 1'b0; rvalid_in = 1'b1; lrdata = 32'hCAFE_0123;
    @(negedge phy_clk);
    chk("init_ret", {rvalid, rdata}, {2'b01, 32'hCAFE_0123});
    step();
    rvalid_in = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // both ports requesting continuously
    do_reset();
    req = 2'b11; we = 2'b11; size[0] = 2'd1; size[1] = 2'd1; lready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_ack(got, 10);
`ifdef DDR_ARB_FIXED_PRIO_EN
      chk($sformatf("contend_grant%0d", k), got, 2'b01);
`else
      chk($sformatf("contend_grant%0d", k), got, (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    req[0] = 1'b0;
    wait_ack(got, 10);
    chk("contend_p0_dropped", got, 2'b10);
    req = 2'b00; lready = 1'b0;

    // read return ordering
    do_reset();
    issue_rd(0, 23'h000040, 2'd2);
    issue_rd(1, 23'h000080, 2'd1);
    for (int b = 0; b < 3; b++) begin
      rvalid_in = 1'b1;
      lrdata = 32'hD000_0000 + b;
      @(negedge phy_clk);
      chk($sformatf("order_ret%0d", b), {rvalid, rdata}, {((b < 2) ? 2'b01 : 2'b10), lrdata});
      step();
    end
    rvalid_in = 1'b0;

    // tag FIFO full: read stalls, write still proceeds
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue_rd(0, ADDR_W'(i), 2'd1);
    req = 2'b11; we[0] = 1'b0; we[1] = 1'b1; size[1] = 2'd1; wdata[1] = 32'h0F0F_0F0F; lready = 1'b1;
    rd_seen = 0; p0_acks = 0; p1_acks = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge phy_clk);
      rd_seen += int'(rd_req);
      p0_acks += int'(ack[0]);
      p1_acks += int'(ack[1]);
      step();
      if (p1_acks != 0) req[1] = 1'b0;
    end
    chk("full_stall", {rd_seen, p0_acks, p1_acks}, {32'd0, 32'd0, 32'd1});
    rvalid_in = 1'b1;
    @(negedge phy_clk);
    chk("full_pop", rvalid, 2'b01);
    step();
    rvalid_in = 1'b0;
    wait_ack(got, 6);
    chk("full_read_issues", got, 2'b01);
    req[0] = 1'b0; lready = 1'b0;
    for (int b = 0; b < DEPTH; b++) begin
      rvalid_in = 1'b1;
      @(negedge phy_clk);
      chk($sformatf("full_drain%0d", b), rvalid, 2'b01);
      step();
    end
    rvalid_in = 1'b0;
    @(negedge phy_clk);
    chk("full_no_unexp", unexp, 1'b0);
    step();

    // unexpected return is sticky until reset
    do_reset();
    rvalid_in = 1'b1; lrdata = 32'h1234_5678;
    @(negedge phy_clk);
    chk("unexp_not_routed", rvalid, 2'b00);
    step();
    rvalid_in = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge phy_clk);
      chk($sformatf("unexp_sticky%0d", t), unexp, 1'b1);
      step();
    end

    // reset in the middle of a write, with a read still outstanding
    do_reset();
    issue_rd(0, 23'h000300, 2'd1);
    req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; wdata[1] = 32'h7777_0000;
    step();
    @(negedge phy_clk);
    chk("midrst_wr_req", wr_req, 1'b1);
    step();
    reset_phy_clk = 1'b1; lready = 1'b1;
    step();
    @(negedge phy_clk);
    chk("midrst_abandon", {wr_req, rd_req, ack, wnext}, 6'h0);
    step();
    reset_phy_clk = 1'b0; req = 2'b00; lready = 1'b0;
    step();
    rvalid_in = 1'b1;
    @(negedge phy_clk);
    chk("midrst_stale_ret", rvalid, 2'b00);
    step();
    rvalid_in = 1'b0;
    @(negedge phy_clk);
    chk("midrst_unexp", unexp, 1'b1);

    // random traffic against a transaction-level model
    do_reset();
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; t_beat[p] = 0;
    end
    ret_q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (act[p] == 0 && cyc < 3000 && $urandom_range(0, 3) == 0) begin
          act[p] = 1;
          t_we[p] = 1'($urandom_range(0, 1));
          t_size[p] = 2'($urandom_range(0, 3));
          t_addr[p] = ADDR_W'($urandom);
          t_data[p][0] = $urandom; t_data[p][1] = $urandom;
          t_be[p][0] = 4'($urandom); t_be[p][1] = 4'($urandom);
          t_beat[p] = 0;
        end
        req[p] = (act[p] != 0);
        we[p] = t_we[p]; addr[p] = t_addr[p]; size[p] = t_size[p];
        wdata[p] = (act[p] != 0 && t_beat[p] < 2) ? t_data[p][t_beat[p]] : 32'h0;
        be[p] = (act[p] != 0 && t_beat[p] < 2) ? t_be[p][t_beat[p]] : 4'h0;
      end
      lready = ($urandom_range(0, 2) != 0);
      exp_rv = 2'b00;
      if (ret_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rvalid_in = 1'b1;
        lrdata = $urandom;
        exp_rv = 2'b01 << ret_q.pop_front();
      end else rvalid_in = 1'b0;
      @(negedge phy_clk);
      chk("rnd_rvalid", rvalid, exp_rv);
      if (rvalid_in) chk("rnd_rdata", rdata, lrdata);
      for (int p = 0; p < 2; p++) begin
        if (wnext[p] || ack[p]) begin
          chk($sformatf("rnd_p%0d_active", p), act[p], 1);
          chk($sformatf("rnd_p%0d_cmd", p), {rd_req, wr_req, laddr, lsize},
              {(t_we[p] ? 2'b01 : 2'b10), t_addr[p], 2'(norm(t_size[p]))});
          if (wnext[p]) begin
            chk($sformatf("rnd_p%0d_wbeat", p), {bb, lwdata, lbe},
                {(t_beat[p] == 0), t_data[p][t_beat[p] % 2], t_be[p][t_beat[p] % 2]});
            t_beat[p]++;
          end
          if (ack[p]) begin
            if (t_we[p]) chk($sformatf("rnd_p%0d_wr_done", p), {wnext[p], 32'(t_beat[p])},
                             {1'b1, 32'(norm(t_size[p]))});
            else for (int b = 0; b < norm(t_size[p]); b++) ret_q.push_back(p);
            act[p] = 0;
          end
        end
      end
      step();
      if (cyc >= 3000 && act[0] == 0 && act[1] == 0 && ret_q.size() == 0) break;
    end
    chk("rnd_drained", {32'(act[0] + act[1]), 32'(ret_q.size())}, 64'h0);
    @(negedge phy_clk);
    chk("rnd_no_unexp", unexp, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
